// File: rtl/serial_link_pkg.sv
// Shared constants and state type for both ends of the push-button serial link.
// The receiver imports the same header constants so both ends agree on framing.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } tx_state_t;

    localparam int         HDR_LEN_DEF  = 4;
    localparam logic [3:0] HDR_PAT_DEF  = 4'b1101;
    localparam int         PAY_LEN_DEF  = 10;
    localparam logic       IDLE_LVL_DEF = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, shift-left payload register; the MSB is the next bit to send.
module tx_shift_reg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load has priority over shift; zeros fill from the LSB side.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = d;
        end else if (shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Frame transmitter: header pattern then payload, one bit per clk_EN strobe.
// All outputs are registered so the receiver sees glitch-free levels.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int                  HDR_LEN  = HDR_LEN_DEF,
    parameter logic [HDR_LEN-1:0]  HDR_PAT  = HDR_LEN'(HDR_PAT_DEF),
    parameter int                  PAY_LEN  = PAY_LEN_DEF,
    parameter logic                IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_EN,
    input  logic               start,
    input  logic [PAY_LEN-1:0] data_in,
    output logic               ser_out,
    output logic               busy,
    output logic               done,
    output logic [3:0]         bit_idx
);

    localparam int CNT_W = $clog2(max_int(HDR_LEN, PAY_LEN));
    localparam int IDX_W = 6;

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ser_q, ser_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]  idx_sum;
    logic [HDR_LEN-1:0] hdr_word;
    logic              load;
    logic              shift_en;
    logic              sh_msb;

    tx_shift_reg #(
        .WIDTH (PAY_LEN)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d        (data_in),
        .msb      (sh_msb)
    );

    // Next-state, counter and serial-bit selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ser_d    = ser_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        // Header bit HDR_LEN-2-cnt lands in the MSB after shifting by cnt+1.
        hdr_word = HDR_PAT << (cnt_q + 1'b1);
        unique case (state_q)
            IDLE: begin
                ser_d  = IDLE_LVL;
                busy_d = 1'b0;
                // clk_EN in the acceptance cycle is deliberately ignored.
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    ser_d   = HDR_PAT[HDR_LEN-1];
                    busy_d  = 1'b1;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (clk_EN) begin
                    if (cnt_q < CNT_W'(HDR_LEN - 1)) begin
                        cnt_d = cnt_q + 1'b1;
                        ser_d = hdr_word[HDR_LEN-1];
                    end else begin
                        cnt_d    = '0;
                        ser_d    = sh_msb;
                        shift_en = 1'b1;
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (clk_EN) begin
                    if (cnt_q < CNT_W'(PAY_LEN - 1)) begin
                        cnt_d    = cnt_q + 1'b1;
                        ser_d    = sh_msb;
                        shift_en = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        ser_d   = IDLE_LVL;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ser_d   = IDLE_LVL;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Debug index follows the state being entered, saturating at 15.
    always_comb begin
        idx_sum = '0;
        unique case (state_d)
            HEADER:  idx_sum = IDX_W'(cnt_d);
            PAYLOAD: idx_sum = IDX_W'(HDR_LEN) + IDX_W'(cnt_d);
            default: idx_sum = '0;
        endcase
        bit_idx_d = (idx_sum > IDX_W'(15)) ? 4'd15 : idx_sum[3:0];
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ser_q     <= IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx with hand-computed expected bit streams.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_EN = 1'b0;
    logic       start = 1'b0;
    logic [9:0] data_in = '0;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic [3:0] bit_idx;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [13:0] rx;
    logic [13:0] seq;
    int done_before;

    serial_frame_tx dut (
        .clk     (clk),
        .rst     (rst),
        .clk_EN  (clk_EN),
        .start   (start),
        .data_in (data_in),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;

    // Count done pulses as seen at clock edges.
    always_ff @(posedge clk) begin
        done_cnt <= done_cnt + (done ? 1 : 0);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe; the receiver-side sample is ser_out just before the edge.
    task automatic strobe_rx();
        rx = {rx[12:0], ser_out};
        clk_EN = 1'b1;
        tick();
        clk_EN = 1'b0;
    endtask

    task automatic accept(input logic [9:0] d);
        data_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        rx = '0;
    endtask

    task automatic run_frame(input logic [9:0] d, input int gap);
        accept(d);
        for (int i = 0; i < 14; i++) begin
            strobe_rx();
            repeat (gap) tick();
        end
        tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_ser", 16'(ser_out), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_idx", 16'(bit_idx), 16'h0);
        rst = 1'b0;
        tick();

        // Basic frame, strobes 5 clocks apart
        accept(10'b1011001110);
        check("acc_ser", 16'(ser_out), 16'h1);
        check("acc_busy", 16'(busy), 16'h1);
        check("acc_idx", 16'(bit_idx), 16'h0);
        seq = 14'b10110110011100;
        done_before = done_cnt;
        for (int i = 1; i <= 14; i++) begin
            strobe_rx();
            check($sformatf("f1_ser%0d", i), 16'(ser_out), 16'(seq[14-i]));
            check($sformatf("f1_idx%0d", i), 16'(bit_idx), (i < 14) ? 16'(i) : 16'h0);
            check($sformatf("f1_busy%0d", i), 16'(busy), (i < 14) ? 16'h1 : 16'h0);
            check($sformatf("f1_done%0d", i), 16'(done), (i < 14) ? 16'h0 : 16'h1);
            if (i < 14) begin
                repeat (4) tick();
                check($sformatf("f1_hold%0d", i), 16'(ser_out), 16'(seq[14-i]));
            end
        end
        tick();
        check("f1_done_clr", 16'(done), 16'h0);
        check("f1_done_cnt", 16'(done_cnt - done_before), 16'h1);
        check("f1_rx", 16'(rx), 16'({4'b1101, 10'b1011001110}));

        // start while busy is ignored and data_in changes do not leak in
        tick();
        accept(10'h2A5);
        done_before = done_cnt;
        for (int i = 1; i <= 14; i++) begin
            strobe_rx();
            if (i < 14) check($sformatf("f2_busy%0d", i), 16'(busy), 16'h1);
            if (i == 3 || i == 9) begin
                start = 1'b1;
                data_in = (i == 3) ? 10'h15A : 10'h0F0;
            end
            tick();
            start = 1'b0;
            if (i < 14) check($sformatf("f2_busyg%0d", i), 16'(busy), 16'h1);
        end
        repeat (3) tick();
        check("f2_rx", 16'(rx), 16'({4'b1101, 10'h2A5}));
        check("f2_nobusy", 16'(busy), 16'h0);
        check("f2_done_cnt", 16'(done_cnt - done_before), 16'h1);

        // start and clk_EN together in IDLE: strobe ignored
        data_in = 10'h155;
        start = 1'b1;
        clk_EN = 1'b1;
        tick();
        start = 1'b0;
        clk_EN = 1'b0;
        rx = '0;
        check("f3_ser0", 16'(ser_out), 16'h1);
        check("f3_idx0", 16'(bit_idx), 16'h0);
        tick();
        strobe_rx();
        check("f3_ser1", 16'(ser_out), 16'h1);
        check("f3_idx1", 16'(bit_idx), 16'h1);
        for (int i = 2; i <= 14; i++) begin
            tick();
            strobe_rx();
        end
        repeat (2) tick();
        check("f3_rx", 16'(rx), 16'({4'b1101, 10'h155}));

        // Async reset mid-cycle during payload bit 5
        accept(10'h3C3);
        for (int i = 1; i <= 9; i++) begin
            strobe_rx();
            tick();
        end
        check("f4_idx9", 16'(bit_idx), 16'h9);
        done_before = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("f4_rst_ser", 16'(ser_out), 16'h0);
        check("f4_rst_busy", 16'(busy), 16'h0);
        check("f4_rst_done", 16'(done), 16'h0);
        check("f4_rst_idx", 16'(bit_idx), 16'h0);
        tick();
        rst = 1'b0;
        clk_EN = 1'b1;
        repeat (3) tick();
        clk_EN = 1'b0;
        tick();
        check("f4_no_done", 16'(done_cnt - done_before), 16'h0);
        check("f4_idle_busy", 16'(busy), 16'h0);
        run_frame(10'h2D9, 2);
        check("f4_rx", 16'(rx), 16'({4'b1101, 10'h2D9}));

        // Loopback-style payload recovery
        run_frame(10'h3FF, 2);
        check("lb_3ff", 16'(rx), 16'({4'b1101, 10'h3FF}));
        run_frame(10'h000, 2);
        check("lb_000", 16'(rx), 16'({4'b1101, 10'h000}));

        // Back-to-back strobes
        accept(10'h1C7);
        done_before = done_cnt;
        for (int i = 1; i <= 14; i++) begin
            rx = {rx[12:0], ser_out};
            clk_EN = 1'b1;
            tick();
            check($sformatf("f6_idx%0d", i), 16'(bit_idx), (i < 14) ? 16'(i) : 16'h0);
        end
        clk_EN = 1'b0;
        check("f6_done", 16'(done), 16'h1);
        tick();
        check("f6_rx", 16'(rx), 16'({4'b1101, 10'h1C7}));
        check("f6_done_cnt", 16'(done_cnt - done_before), 16'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
